valid_ready_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream valid/ready channel between N upstream valid_ready_master-style requesters.
- Each requester presents 8-bit data with valid. The arbiter grants one requester per accepted beat and registers its data, source ID and valid into a single output stage.
- Sits between several byte sources and one valid/ready slave.
- Also keeps a wrapping count of delivered beats for debug.

---
 rtl/valid_ready_rr_arbiter_pkg.sv | 41 ++++
 rtl/valid_ready_rr_arbiter_rr_grant_logic.sv | 33 +++
 rtl/valid_ready_rr_arbiter.sv | 71 +++++++
 tb/tb_valid_ready_rr_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/valid_ready_rr_arbiter_pkg.sv
// Shared widths and round-robin helpers for valid/ready arbiters.
// Functions work on an 8-wide vector so any requester count from 2 to 8 can reuse them.
package valid_ready_rr_arbiter_pkg;

    localparam int DEF_DW  = 8;
    localparam int DEF_IDW = 2;
    localparam int DEF_CW  = 16;
    localparam int MAX_N   = 8;
    localparam int MAX_IDW = 3;

    // One-hot grant: first eligible index scanning upward from ptr+1, wrapping at n.
    function automatic logic [MAX_N-1:0] rr_grant(input logic [MAX_N-1:0]   elig,
                                                  input logic [MAX_IDW-1:0] ptr,
                                                  input int                 n);
        logic [MAX_N-1:0] g;
        logic             found;
        int               idx;
        g     = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_N; i++) begin
            if (i <= n) begin
                idx = (int'(ptr) + i) % n;
                if (!found && elig[idx[MAX_IDW-1:0]]) begin
                    g[idx[MAX_IDW-1:0]] = 1'b1;
                    found               = 1'b1;
                end
            end
        end
        return g;
    endfunction

    function automatic logic [MAX_IDW-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | MAX_IDW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/valid_ready_rr_arbiter_rr_grant_logic.sv
// Combinational round-robin grant: eligible vector and last-winner pointer in,
// one-hot grant, its index and an any-grant flag out.
module valid_ready_rr_arbiter_rr_grant_logic
    import valid_ready_rr_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = DEF_IDW
) (
    input  logic [N-1:0]   eligible,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           any_grant
);

    logic [MAX_N-1:0]   elig_w;
    logic [MAX_N-1:0]   grant_w;
    logic [MAX_IDW-1:0] ptr_w;
    logic [MAX_IDW-1:0] idx_w;

    always_comb begin
        elig_w          = '0;
        elig_w[N-1:0]   = eligible;
        ptr_w           = MAX_IDW'(ptr);
        grant_w         = rr_grant(elig_w, ptr_w, N);
        idx_w           = onehot_to_idx(grant_w);
    end

    assign grant     = grant_w[N-1:0];
    assign any_grant = |grant_w;
    assign grant_idx = IDW'(idx_w);

endmodule

// File: rtl/valid_ready_rr_arbiter.sv
// Round-robin arbiter: N byte sources share one registered valid/ready output stage.
// Handshakes: a beat moves on any edge where valid and ready are both high; valid never drops while ready is low.
module valid_ready_rr_arbiter
    import valid_ready_rr_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int DW  = DEF_DW,
    parameter int IDW = DEF_IDW,
    parameter int CW  = DEF_CW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    i_req_valid,
    input  logic [N*DW-1:0] i_req_data,
    output logic [N-1:0]    o_req_ready,
    input  logic [N-1:0]    i_req_mask,
    output logic            o_s_valid,
    output logic [DW-1:0]   o_s_data,
    output logic [IDW-1:0]  o_s_id,
    input  logic            i_s_ready,
    output logic [CW-1:0]   o_beat_cnt
);

    logic [IDW-1:0] rr_ptr;
    logic [N-1:0]   eligible;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_idx;
    logic           any_grant;
    logic           load_en;

    // The output stage may take a new beat when it is empty or being drained this edge.
    assign load_en     = rst_n & (~o_s_valid | i_s_ready);
    assign eligible    = i_req_valid & i_req_mask;
    assign o_req_ready = {N{load_en}} & grant;

    valid_ready_rr_arbiter_rr_grant_logic #(
        .N   (N),
        .IDW (IDW)
    ) u_grant (
        .eligible  (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_s_valid  <= 1'b0;
            o_s_data   <= '0;
            o_s_id     <= '0;
            o_beat_cnt <= '0;
            rr_ptr     <= IDW'(N - 1);
        end else begin
            if (o_s_valid && i_s_ready) begin
                o_beat_cnt <= o_beat_cnt + CW'(1);
            end
            if (load_en) begin
                if (any_grant) begin
                    o_s_valid <= 1'b1;
                    o_s_data  <= i_req_data[grant_idx*DW +: DW];
                    o_s_id    <= grant_idx;
                    rr_ptr    <= grant_idx;
                end else begin
                    o_s_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_valid_ready_rr_arbiter.sv
// Directed bench for valid_ready_rr_arbiter (N=4): reset, fairness, stall, mask, idle, counter wrap.
module tb_valid_ready_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic [3:0]  i_req_mask;
    logic        o_s_valid;
    logic [7:0]  o_s_data;
    logic [1:0]  o_s_id;
    logic        i_s_ready;
    logic [15:0] o_beat_cnt;

    int checks;
    int failures;

    valid_ready_rr_arbiter #(
        .N(4), .DW(8), .IDW(2), .CW(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .i_req_mask  (i_req_mask),
        .o_s_valid   (o_s_valid),
        .o_s_data    (o_s_data),
        .o_s_id      (o_s_id),
        .i_s_ready   (i_s_ready),
        .o_beat_cnt  (o_beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] id,
                             input logic [7:0] data, input logic [15:0] cnt);
        check({tag, "_valid"}, 32'(o_s_valid), 32'(v));
        check({tag, "_id"}, 32'(o_s_id), 32'(id));
        check({tag, "_data"}, 32'(o_s_data), 32'(data));
        check({tag, "_cnt"}, 32'(o_beat_cnt), 32'(cnt));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        i_req_valid = 4'hF;
        i_req_mask  = 4'hF;
        i_req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        i_s_ready   = 1'b1;

        // Reset held for three edges with all requesters valid
        repeat (3) step();
        check_out("reset", 1'b0, 2'd0, 8'h00, 16'd0);
        check("reset_req_ready", 32'(o_req_ready), 32'h0);

        // Fairness: requester 0 first after reset, then 1,2,3,0
        rst_n = 1'b1;
        #1;
        check("first_req_ready", 32'(o_req_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            step();
            check_out($sformatf("fair%0d", k), 1'b1, 2'(k % 4), 8'(8'h10 + (k % 4)), 16'(k));
        end

        // Stall holding id 1
        step();
        check_out("pre_stall", 1'b1, 2'd1, 8'h11, 16'd5);
        i_s_ready = 1'b0;
        #1;
        check("stall_req_ready", 32'(o_req_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check_out($sformatf("stall%0d", k), 1'b1, 2'd1, 8'h11, 16'd5);
            check($sformatf("stall%0d_req_ready", k), 32'(o_req_ready), 32'h0);
        end
        i_s_ready = 1'b1;
        #1;
        check("unstall_req_ready", 32'(o_req_ready), 32'h4);
        step();
        check_out("after_stall", 1'b1, 2'd2, 8'h12, 16'd6);

        // Mask 1010: ids alternate 3,1,3
        i_req_mask = 4'b1010;
        step();
        check_out("mask0", 1'b1, 2'd3, 8'h13, 16'd7);
        step();
        check_out("mask1", 1'b1, 2'd1, 8'h11, 16'd8);
        step();
        check_out("mask2", 1'b1, 2'd3, 8'h13, 16'd9);

        // Stall holding id 3, then mask it out mid-stall
        i_s_ready = 1'b0;
        step();
        step();
        check_out("mstall0", 1'b1, 2'd3, 8'h13, 16'd9);
        i_req_mask = 4'b0010;
        step();
        check_out("mstall1", 1'b1, 2'd3, 8'h13, 16'd9);
        i_s_ready = 1'b1;
        step();
        check_out("mdrain0", 1'b1, 2'd1, 8'h11, 16'd10);
        step();
        check_out("mdrain1", 1'b1, 2'd1, 8'h11, 16'd11);
        step();
        check_out("mdrain2", 1'b1, 2'd1, 8'h11, 16'd12);

        // Idle, then a single beat from requester 2
        i_req_valid = 4'h0;
        i_req_mask  = 4'hF;
        step();
        check_out("idle0", 1'b0, 2'd1, 8'h11, 16'd13);
        step();
        check_out("idle1", 1'b0, 2'd1, 8'h11, 16'd13);
        i_req_valid = 4'b0100;
        #1;
        check("sparse_req_ready", 32'(o_req_ready), 32'h4);
        step();
        i_req_valid = 4'h0;
        check_out("sparse", 1'b1, 2'd2, 8'h12, 16'd13);
        step();
        check_out("sparse_done0", 1'b0, 2'd2, 8'h12, 16'd14);
        step();
        check_out("sparse_done1", 1'b0, 2'd2, 8'h12, 16'd14);

        // Counter wrap: clear, then stream 65536 loads
        rst_n = 1'b0;
        step();
        check_out("reset2", 1'b0, 2'd0, 8'h00, 16'd0);
        rst_n       = 1'b1;
        i_req_valid = 4'hF;
        repeat (65536) step();
        check("wrap_ffff", 32'(o_beat_cnt), 32'hFFFF);
        check("wrap_valid", 32'(o_s_valid), 32'h1);
        step();
        check("wrap_zero", 32'(o_beat_cnt), 32'h0);

        // Mid-stream reset discards the held beat
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(o_req_ready), 32'h0);
        step();
        check_out("midrst", 1'b0, 2'd0, 8'h00, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
